// File: rtl/slab_interval_reduce_pkg.sv
// Shared definitions for the slab interval reducer: FloPoCo 11_7 word layout,
// exception codes and small field helpers.
package slab_interval_reduce_pkg;

    localparam int FP_WE      = 7;
    localparam int FP_WF      = 11;
    localparam int FP_MSB     = FP_WE + FP_WF + 2;
    localparam int FP_EXC_HI  = FP_MSB;
    localparam int FP_EXC_LO  = FP_MSB - 1;
    localparam int FP_SIGN    = FP_WE + FP_WF;
    localparam int FP_EXP_HI  = FP_WE + FP_WF - 1;
    localparam int FP_EXP_LO  = FP_WF;
    localparam int FP_FRAC_HI = FP_WF - 1;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    typedef logic [FP_MSB:0] fp_word_t;

    localparam fp_word_t FP_ZERO = 21'h00000;
    localparam fp_word_t FP_ONE  = 21'h09F800;

    function automatic logic fp_is_nan(input fp_word_t w);
        return w[FP_EXC_HI:FP_EXC_LO] == EXC_NAN;
    endfunction

    // Zeros are never negative, so +0 and -0 fall into the same class.
    function automatic logic fp_is_neg(input fp_word_t w);
        return w[FP_SIGN] && (w[FP_EXC_HI:FP_EXC_LO] == EXC_NORM ||
                              w[FP_EXC_HI:FP_EXC_LO] == EXC_INF);
    endfunction

endpackage

// File: rtl/fp_cmp_11_7.sv
// Same-cycle ordering of two FloPoCo 11_7 words with IEEE-like semantics.
module fp_cmp_11_7
    import slab_interval_reduce_pkg::*;
(
    input  fp_word_t a,
    input  fp_word_t b,
    output logic     lt,
    output logic     eq,
    output logic     unord
);

    localparam int MAG_W = FP_WE + FP_WF + 2;

    // Magnitude key: exception class on top so zero < normal < inf.
    function automatic logic [MAG_W-1:0] fp_mag(input fp_word_t w);
        logic [MAG_W-1:0] m;
        case (w[FP_EXC_HI:FP_EXC_LO])
            EXC_NORM: m = {EXC_NORM, w[FP_EXP_HI:0]};
            EXC_INF:  m = {EXC_INF, {(FP_WE + FP_WF){1'b0}}};
            default:  m = '0;
        endcase
        return m;
    endfunction

    logic [MAG_W-1:0] mag_a, mag_b;
    logic             neg_a, neg_b;

    assign mag_a = fp_mag(a);
    assign mag_b = fp_mag(b);
    assign neg_a = fp_is_neg(a);
    assign neg_b = fp_is_neg(b);
    assign unord = fp_is_nan(a) || fp_is_nan(b);

    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        if (!unord) begin
            if (neg_a != neg_b)
                lt = neg_a;
            else if (neg_a)
                lt = mag_a > mag_b;
            else
                lt = mag_a < mag_b;
            eq = (neg_a == neg_b) && (mag_a == mag_b);
        end
    end

endmodule

// File: rtl/slab_interval_reduce.sv
// Reduces NAXES per-axis (t_near, t_far) beats of a ray to (max near, min far)
// and issues a registered hit verdict one cycle after the last axis.
module slab_interval_reduce
    import slab_interval_reduce_pkg::*;
#(
    parameter int WIDTH = FP_MSB,
    parameter int WE    = FP_WE,
    parameter int WF    = FP_WF,
    parameter int NAXES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH:0] in_tnear,
    input  logic [WIDTH:0] in_tfar,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:0] out_tenter,
    output logic [WIDTH:0] out_texit,
    output logic           out_hit,
    output logic           out_nan
);

    localparam int              CNT_W  = (NAXES > 1) ? $clog2(NAXES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NAXES - 1);
    localparam int              SIGN_B = WE + WF;

    logic [CNT_W-1:0] axis_cnt_q, axis_cnt_d;
    logic [WIDTH:0]   acc_near_q, acc_near_d;
    logic [WIDTH:0]   acc_far_q, acc_far_d;
    logic             acc_nan_q, acc_nan_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   out_tenter_q, out_texit_q;
    logic             out_hit_q, out_nan_q;

    logic accept, first, last;
    logic near_lt, far_lt, enter_gt_exit, exit_neg, hit_d;
    logic near_eq, far_eq, hit_eq, near_un, far_un, hit_un;
    logic cmp_unused;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign first    = axis_cnt_q == '0;
    assign last     = axis_cnt_q == LAST;

    fp_cmp_11_7 u_cmp_near (.a(acc_near_q), .b(in_tnear),   .lt(near_lt), .eq(near_eq), .unord(near_un));
    fp_cmp_11_7 u_cmp_far  (.a(in_tfar),    .b(acc_far_q),  .lt(far_lt),  .eq(far_eq),  .unord(far_un));
    // texit lt tenter is the same question as tenter gt texit.
    fp_cmp_11_7 u_cmp_hit  (.a(acc_far_d),  .b(acc_near_d), .lt(enter_gt_exit), .eq(hit_eq), .unord(hit_un));

    assign cmp_unused = ^{near_eq, far_eq, hit_eq, near_un, far_un, hit_un};

    always_comb begin
        acc_near_d = (first || near_lt) ? in_tnear : acc_near_q;
        acc_far_d  = (first || far_lt)  ? in_tfar  : acc_far_q;
        acc_nan_d  = (!first && acc_nan_q) || fp_is_nan(in_tnear) || fp_is_nan(in_tfar);
    end

    // A signed zero exit is still a valid (non-negative) exit distance.
    assign exit_neg = acc_far_d[SIGN_B] &&
                      (acc_far_d[WIDTH:WIDTH-1] == EXC_NORM || acc_far_d[WIDTH:WIDTH-1] == EXC_INF);
    assign hit_d    = !acc_nan_d && !enter_gt_exit && !exit_neg;

    always_comb begin
        axis_cnt_d = axis_cnt_q;
        if (accept)
            axis_cnt_d = last ? '0 : axis_cnt_q + 1'b1;
        out_valid_d = out_valid_q;
        if (accept && last)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            axis_cnt_q   <= '0;
            acc_near_q   <= '0;
            acc_far_q    <= '0;
            acc_nan_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_tenter_q <= '0;
            out_texit_q  <= '0;
            out_hit_q    <= 1'b0;
            out_nan_q    <= 1'b0;
        end else begin
            axis_cnt_q  <= axis_cnt_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                acc_near_q <= acc_near_d;
                acc_far_q  <= acc_far_d;
                acc_nan_q  <= acc_nan_d;
            end
            if (accept && last) begin
                out_tenter_q <= acc_near_d;
                out_texit_q  <= acc_far_d;
                out_hit_q    <= hit_d;
                out_nan_q    <= acc_nan_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_tenter = out_tenter_q;
    assign out_texit  = out_texit_q;
    assign out_hit    = out_hit_q;
    assign out_nan    = out_nan_q;

endmodule
